// File: rtl/vga_text_writer.sv
// vga_text_writer: turns a byte stream into character-memory writes for the
// VGA text adapter. Keeps a cursor, wraps lines, and handles CR, LF, BS and FF
// (clear screen). No scrolling: a new line only blanks the row it moves onto.
module vga_text_writer #(
    parameter int COLUMNS        = 40,
    parameter int ROWS           = 30,
    parameter int ADDR_WIDTH     = 11,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk_20_mhz,
    input  logic                  reset_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [6:0]            char_output,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] cursor_address
);

    localparam int CW    = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    // One extra bit so the clear counter can hold ROWS*COLUMNS itself.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int TOTAL = ROWS * COLUMNS;

    localparam logic [6:0] SPACE = 7'h20;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        CLEAR_ROW = 2'd2,
        CLEAR_ALL = 2'd3
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR_ALL : IDLE;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [6:0]            char_q, char_d;
    logic                  we_q, we_d;
    // Set when the pending WRITE is a printable character, so the cursor
    // advances once the strobe has gone out (backspace moves it beforehand).
    logic                  adv_q, adv_d;

    logic [RW-1:0]         next_row;

    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [RW-1:0] r,
                                                        input logic [CNT_W-1:0] c);
        return ADDR_WIDTH'(32'(r) * 32'(COLUMNS) + 32'(c));
    endfunction

    assign in_ready       = (state_q == IDLE);
    assign address        = addr_q;
    assign char_output    = char_q;
    assign write_enable   = we_q;
    assign cursor_address = cell_addr(row_q, CNT_W'(col_q));

    // Row the cursor moves to on a newline, wrapping to the top of the screen.
    always_comb begin
        next_row = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    end

    // State register and all datapath registers; reset clears everything.
    always_ff @(posedge clk_20_mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            char_q  <= '0;
            we_q    <= 1'b0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            char_q  <= char_d;
            we_q    <= we_d;
            adv_q   <= adv_d;
        end
    end

    // Next-state logic: byte decode, cursor movement and clear sequencing.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        char_d  = char_q;
        we_d    = 1'b0;
        adv_d   = adv_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        addr_d  = cursor_address;
                        char_d  = in_data[6:0];
                        we_d    = 1'b1;
                        adv_d   = 1'b1;
                        state_d = WRITE;
                    end else begin
                        case (in_data)
                            8'h0D: col_d = '0;
                            8'h0A: begin
                                // First blanking strobe is issued right away.
                                col_d   = '0;
                                row_d   = next_row;
                                addr_d  = cell_addr(next_row, '0);
                                char_d  = SPACE;
                                we_d    = 1'b1;
                                cnt_d   = CNT_W'(1);
                                state_d = CLEAR_ROW;
                            end
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d   = col_q - CW'(1);
                                    addr_d  = cell_addr(row_q, CNT_W'(col_q - CW'(1)));
                                    char_d  = SPACE;
                                    we_d    = 1'b1;
                                    adv_d   = 1'b0;
                                    state_d = WRITE;
                                end
                            end
                            8'h0C: begin
                                cnt_d   = '0;
                                state_d = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            WRITE: begin
                state_d = IDLE;
                if (adv_q) begin
                    if (col_q == CW'(COLUMNS - 1)) begin
                        // Wrap: blanking of the new row follows with no gap.
                        col_d   = '0;
                        row_d   = next_row;
                        addr_d  = cell_addr(next_row, '0);
                        char_d  = SPACE;
                        we_d    = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = CLEAR_ROW;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end

            CLEAR_ROW: begin
                if (cnt_q == CNT_W'(COLUMNS)) begin
                    state_d = IDLE;
                end else begin
                    addr_d = cell_addr(row_q, cnt_q);
                    char_d = SPACE;
                    we_d   = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end

            CLEAR_ALL: begin
                if (cnt_q == CNT_W'(TOTAL)) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    addr_d = ADDR_WIDTH'(cnt_q);
                    char_d = SPACE;
                    we_d   = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer with default geometry (40x30, 11-bit
// addresses, clear on reset).
module tb_vga_text_writer;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] address;
    logic [6:0]  char_output;
    logic        write_enable;
    logic [10:0] cursor_address;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int log_addr[$];
    int log_chr[$];
    int log_cyc[$];

    vga_text_writer #(
        .COLUMNS(40), .ROWS(30), .ADDR_WIDTH(11), .CLEAR_ON_RESET(1)
    ) dut (
        .clk_20_mhz    (clk),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .address       (address),
        .char_output   (char_output),
        .write_enable  (write_enable),
        .cursor_address(cursor_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            log_addr.push_back(int'(address));
            log_chr.push_back(int'(char_output));
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_chr.delete();
        log_cyc.delete();
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Present one byte as soon as the DUT is ready; returns 1ns after the
    // accepting edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Number of logged strobes from index 'first' that differ from an
    // ascending run of 'chr' starting at 'base'.
    function automatic int seq_bad(input int first, input int count, input int base, input int chr);
        int bad = 0;
        for (int k = 0; k < count; k++) begin
            if (first + k >= log_addr.size()) bad++;
            else if (log_addr[first + k] != base + k || log_chr[first + k] != chr) bad++;
        end
        return bad;
    endfunction

    initial begin
        int n;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();

        check("rst_we",     32'(write_enable),   32'd0);
        check("rst_addr",   32'(address),        32'd0);
        check("rst_char",   32'(char_output),    32'd0);
        check("rst_cursor", 32'(cursor_address), 32'd0);
        check("rst_ready",  32'(in_ready),       32'd0);

        // Power-up clear of the whole screen.
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(1300, "clr");
        check("clr_count",  32'(log_addr.size()), 32'd1200);
        check("clr_seq",    32'(seq_bad(0, 1200, 0, 8'h20)), 32'd0);
        if (log_cyc.size() == 1200)
            check("clr_contig", 32'(log_cyc[1199] - log_cyc[0]), 32'd1199);
        check("clr_cursor", 32'(cursor_address), 32'd0);

        // "AB" from home: strobe in the cycle after acceptance, ready back next.
        clear_log();
        send(8'h41);
        tick();
        check("A_we",    32'(write_enable), 32'd1);
        check("A_addr",  32'(address),      32'd0);
        check("A_char",  32'(char_output),  32'h41);
        check("A_busy",  32'(in_ready),     32'd0);
        tick();
        check("A_we_off", 32'(write_enable),   32'd0);
        check("A_ready",  32'(in_ready),       32'd1);
        check("A_cursor", 32'(cursor_address), 32'd1);
        send(8'h42);
        tick();
        check("B_we",    32'(write_enable), 32'd1);
        check("B_addr",  32'(address),      32'd1);
        check("B_char",  32'(char_output),  32'h42);
        check("B_busy",  32'(in_ready),     32'd0);
        tick();
        check("B_ready",  32'(in_ready),       32'd1);
        check("B_cursor", 32'(cursor_address), 32'd2);
        check("AB_count", 32'(log_addr.size()), 32'd2);

        // CR back to column 0: no strobe, ready stays high.
        send(8'h0D);
        tick();
        check("cr_we",     32'(write_enable),   32'd0);
        check("cr_ready",  32'(in_ready),       32'd1);
        check("cr_cursor", 32'(cursor_address), 32'd0);

        // 40 'x' from home: wrap then 40 blanks on row 1 back to back.
        clear_log();
        for (int i = 0; i < 40; i++) send(8'h78);
        wait_ready(100, "wrap");
        check("wrap_count",  32'(log_addr.size()), 32'd80);
        check("wrap_x",      32'(seq_bad(0, 40, 0, 8'h78)), 32'd0);
        check("wrap_sp",     32'(seq_bad(40, 40, 40, 8'h20)), 32'd0);
        if (log_cyc.size() == 80)
            check("wrap_contig", 32'(log_cyc[79] - log_cyc[39]), 32'd40);
        check("wrap_cursor", 32'(cursor_address), 32'd40);

        // Move to row 2, column 5.
        send(8'h0A);
        wait_ready(100, "lf2");
        for (int i = 0; i < 5; i++) send(8'h61);
        wait_ready(10, "col5");
        check("col5_cursor", 32'(cursor_address), 32'd85);

        // Backspace at column 5.
        send(8'h08);
        tick();
        check("bs_we",   32'(write_enable), 32'd1);
        check("bs_addr", 32'(address),      32'd84);
        check("bs_char", 32'(char_output),  32'h20);
        tick();
        check("bs_cursor", 32'(cursor_address), 32'd84);
        check("bs_ready",  32'(in_ready),       32'd1);

        // CR then backspace at column 0: neither writes.
        send(8'h0D);
        tick();
        check("cr2_we",     32'(write_enable),   32'd0);
        check("cr2_cursor", 32'(cursor_address), 32'd80);
        send(8'h08);
        tick();
        check("bs0_we",     32'(write_enable),   32'd0);
        check("bs0_cursor", 32'(cursor_address), 32'd80);
        check("bs0_ready",  32'(in_ready),       32'd1);

        // Ignored bytes are consumed without writes.
        clear_log();
        send(8'h80);
        send(8'h01);
        tick();
        check("ign_we",     32'(write_enable),   32'd0);
        check("ign_ready",  32'(in_ready),       32'd1);
        check("ign_count",  32'(log_addr.size()), 32'd0);
        check("ign_cursor", 32'(cursor_address), 32'd80);

        // Down to row 29, then LF wraps to row 0.
        for (int i = 0; i < 27; i++) send(8'h0A);
        wait_ready(100, "row29");
        check("row29_cursor", 32'(cursor_address), 32'd1160);
        clear_log();
        send(8'h0A);
        n = 0;
        tick();
        while (in_ready !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("lf_busy_cycles", 32'(n), 32'd40);
        check("rw_count",  32'(log_addr.size()), 32'd40);
        check("rw_seq",    32'(seq_bad(0, 40, 0, 8'h20)), 32'd0);
        check("rw_cursor", 32'(cursor_address), 32'd0);

        // Form feed interrupted by reset after 100 strobes.
        clear_log();
        send(8'h0C);
        n = 0;
        while (log_addr.size() < 100 && n < 300) begin
            tick();
            n++;
        end
        check("ff_count100", 32'(log_addr.size()), 32'd100);
        check("ff_seq",      32'(seq_bad(0, 100, 0, 8'h20)), 32'd0);
        reset_n = 1'b0;
        #1;
        check("ff_rst_we",   32'(write_enable), 32'd0);
        check("ff_rst_addr", 32'(address),      32'd0);
        repeat (2) tick();
        clear_log();
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(1300, "reclr");
        check("reclr_count",  32'(log_addr.size()), 32'd1200);
        check("reclr_seq",    32'(seq_bad(0, 1200, 0, 8'h20)), 32'd0);
        check("reclr_cursor", 32'(cursor_address), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
